adc_spi_sampler: RTL and testbench
==================================

Name: adc_spi_sampler

Overview:
Parametrised SPI master for single-channel serial ADCs (ADCS7476-class) that frames conversions with cs_n and sck and shifts in DATA_W bits MSB-first from sdo. It generalises our fixed 12-bit / 1 MHz ADC reader with configurable clock divider, frame length, leading-bit offset and CS quiet time. It adds start and continuous modes, a one-cycle sample_valid strobe and a busy flag. It sits between the ADC pins and the twinning/compare logic.

Parameters:
CLK_DIV, 50, clk cycles per sck period; even, >= 4 (50 MHz / 50 = 1 MHz sck)
DATA_W, 12, number of data bits captured per frame
LEAD_BITS, 4, sck rising edges skipped before the first data bit (leading zeros)
FRAME_LEN, 16, sck periods per conversion; LEAD_BITS + DATA_W <= FRAME_LEN
QUIET_CYC, 2, sck periods cs_n is held high between conversions
AVG_LOG2, 2, log2 of averaging group size (used only with ADC_AVG_EN)

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  asynchronous, active-low reset
start  input  1  request one conversion; level or pulse
continuous  input  1  1 = back-to-back conversions while held
sdo  input  1  serial data from ADC (MISO)
sck  output  1  serial clock to ADC
cs_n  output  1  chip select to ADC, active low
sample  output  DATA_W  last completed conversion result
sample_valid  output  1  one-clk pulse when sample updates
busy  output  1  high in any state other than IDLE
avg  output  DATA_W  averaged result (ADC_AVG_EN only)
avg_valid  output  1  one-clk pulse when avg updates (ADC_AVG_EN only)

Behaviour:
- Reset: clk is rst; reset is asynchronous, active-low. State IDLE, cs_n=1, sck=0, sample=0, sample_valid=0, busy=0, avg=0, avg_valid=0, divider/bit counters=0, pending=0. Asserting reset mid-frame aborts immediately: cs_n high and sck low in the same cycle; no sample_valid is produced.
- States: IDLE -> SETUP -> SHIFT -> DONE -> QUIET -> (SETUP | IDLE).
- IDLE: cs_n=1, sck=0. If start or continuous is sampled high, go to SETUP next cycle.
- SETUP: cs_n=0, sck=0 for CLK_DIV/2 cycles, then SHIFT.
- SHIFT: FRAME_LEN periods of CLK_DIV cycles each. Divider div counts 0..CLK_DIV-1. sck=1 while div < CLK_DIV/2, else 0.
- Bit capture: on the cycle with div==0 in period k (sck rising edge), sdo is shifted into an internal register when LEAD_BITS <= k < LEAD_BITS+DATA_W. Capture is MSB first; other periods are ignored.
- DONE (1 cycle): cs_n=1, sck=0. Shift register is copied to sample, and sample_valid=1. sample never shows partial frames.
- QUIET: cs_n=1, sck=0 for QUIET_CYC*CLK_DIV cycles. At exit, go to SETUP if continuous==1 or pending==1 (clear pending), else go to IDLE.
- pending: set by start high in any non-IDLE state; cleared on reset or when consumed. Multiple starts during one frame collapse to a single pending request.
- Latency: start sampled high in IDLE at cycle t -> cs_n low at t+1; sample_valid at t+1+CLK_DIV/2+FRAME_LEN*CLK_DIV (defaults: t+826).
- Continuous throughput: CLK_DIV/2 + FRAME_LEN*CLK_DIV + 1 + QUIET_CYC*CLK_DIV cycles per sample (defaults: 926).
- continuous dropped mid-frame: the current frame completes normally, then the block returns to IDLE unless pending is set.
- Simultaneous start and continuous: treated as one request; no extra pending is set.

Optional Feature:
Macro ADC_AVG_EN.
- Defined: a DATA_W+AVG_LOG2-bit accumulator adds each new sample. After 2^AVG_LOG2 samples, avg = acc >> AVG_LOG2 (truncated), avg_valid pulses one cycle after the completing sample_valid, and the accumulator restarts from 0. Reset or an IDLE entry clears the accumulator and its count.
- Undefined: no accumulator logic is built; avg is tied to 0 and avg_valid to 0.

Test Plan:
- Single shot: ADC model drives 4 zeros then 0xA5C MSB-first on sck falling edges; pulse start -> cs_n low for 825 cycles, 16 sck pulses at 1 MHz, sample=0xA5C, sample_valid high exactly one cycle at t+826, busy low after QUIET.
- Continuous: hold continuous, model returns 0x001, 0xFFF, 0x800 -> three sample_valid pulses spaced exactly 926 cycles apart, with the values in order; cs_n high 101 cycles between frames.
- Pending start: pulse start twice during SHIFT -> exactly one further conversion follows QUIET, then IDLE.
- Reset mid-frame: assert rst at bit 7 -> cs_n=1, sck=0 immediately; sample stays 0, no sample_valid. After release, a new start gives a correct frame.
- Parameter sweep: CLK_DIV=4, DATA_W=8, LEAD_BITS=2, FRAME_LEN=12, QUIET_CYC=1, value 0x3C -> sample=0x3C, sample_valid at t+1+2+48.
- ADC_AVG_EN: continuous samples 100, 101, 102, 104 -> avg=101 (407>>2), avg_valid one cycle after the 4th sample_valid; without the macro, avg stays 0.

Source files
------------

// File: rtl/adc_spi_sampler.sv
// rtl/adc_spi_sampler.sv - SPI master that frames and captures ADCS7476-class serial ADC conversions
// Optional macro ADC_AVG_EN builds a 2**AVG_LOG2-sample averager on the avg/avg_valid outputs.
module adc_spi_sampler #(
   parameter int CLK_DIV   = 50,
   parameter int DATA_W    = 12,
   parameter int LEAD_BITS = 4,
   parameter int FRAME_LEN = 16,
   parameter int QUIET_CYC = 2,
   parameter int AVG_LOG2  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              continuous,
   input  logic              sdo,
   output logic              sck,
   output logic              cs_n,
   output logic [DATA_W-1:0] sample,
   output logic              sample_valid,
   output logic              busy,
   output logic [DATA_W-1:0] avg,
   output logic              avg_valid
);
   localparam int HALF    = CLK_DIV / 2;
   localparam int QUIET_N = QUIET_CYC * CLK_DIV;
   localparam int CNT_MAX = (QUIET_N > HALF) ? QUIET_N : HALF;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int DIV_W   = $clog2(CLK_DIV);
   localparam int K_W     = $clog2(FRAME_LEN + 1);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_N - 1);
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_FALL   = DIV_W'(HALF - 1);
   localparam logic [K_W-1:0]   K_FIRST    = K_W'(LEAD_BITS);
   localparam logic [K_W-1:0]   K_END      = K_W'(LEAD_BITS + DATA_W);
   localparam logic [K_W-1:0]   K_LAST     = K_W'(FRAME_LEN - 1);

   generate
      if (CLK_DIV < 4 || (CLK_DIV % 2) != 0 || LEAD_BITS + DATA_W > FRAME_LEN ||
          DATA_W < 2 || QUIET_CYC < 1 || AVG_LOG2 < 0) begin : g_bad_params
         $error("adc_spi_sampler: illegal parameter combination");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, QUIET} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DIV_W-1:0]  div;
   logic [K_W-1:0]    k;
   logic [DATA_W-1:0] shreg;
   logic              pending;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= '0;
         div          <= '0;
         k            <= '0;
         shreg        <= '0;
         pending      <= 1'b0;
         sck          <= 1'b0;
         cs_n         <= 1'b1;
         sample       <= '0;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         // A start that coincides with continuous is already served by continuous.
         if (state != IDLE && start && !continuous)
            pending <= 1'b1;
         case (state)
            IDLE: begin
               if (start || continuous) begin
                  state <= SETUP;
                  cs_n  <= 1'b0;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
            end
            SETUP: begin
               if (cnt == SETUP_LAST) begin
                  state <= SHIFT;
                  sck   <= 1'b1;
                  div   <= '0;
                  k     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (div == '0 && k >= K_FIRST && k < K_END)
                  shreg <= {shreg[DATA_W-2:0], sdo};
               if (div == DIV_LAST) begin
                  div <= '0;
                  if (k == K_LAST) begin
                     state        <= DONE;
                     cs_n         <= 1'b1;
                     sck          <= 1'b0;
                     sample       <= shreg;
                     sample_valid <= 1'b1;
                  end else begin
                     k   <= k + 1'b1;
                     sck <= 1'b1;
                  end
               end else begin
                  div <= div + 1'b1;
                  if (div == DIV_FALL)
                     sck <= 1'b0;
               end
            end
            DONE: begin
               state <= QUIET;
               cnt   <= '0;
            end
            QUIET: begin
               if (cnt == QUIET_LAST) begin
                  if (continuous || pending) begin
                     state   <= SETUP;
                     cs_n    <= 1'b0;
                     cnt     <= '0;
                     pending <= 1'b0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cs_n  <= 1'b1;
               sck   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ADC_AVG_EN
   localparam int ACC_W  = DATA_W + AVG_LOG2;
   localparam int ACNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'((1 << AVG_LOG2) - 1);

   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_sum;
   logic [ACNT_W-1:0] acnt;

   assign acc_sum = acc + ACC_W'(sample);

   // Accumulates on the sample_valid cycle so avg_valid lands exactly one cycle later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc       <= '0;
         acnt      <= '0;
         avg       <= '0;
         avg_valid <= 1'b0;
      end else begin
         avg_valid <= 1'b0;
         if (state == IDLE) begin
            acc  <= '0;
            acnt <= '0;
         end else if (sample_valid) begin
            if (acnt == ACNT_LAST) begin
               avg       <= acc_sum[ACC_W-1:AVG_LOG2];
               avg_valid <= 1'b1;
               acc       <= '0;
               acnt      <= '0;
            end else begin
               acc  <= acc_sum;
               acnt <= acnt + 1'b1;
            end
         end
      end
   end
`else
   assign avg       = '0;
   assign avg_valid = 1'b0;
`endif

endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb/tb_adc_spi_sampler.sv - directed self-checking bench for adc_spi_sampler
// Covers default and small-parameter instances; avg checks follow ADC_AVG_EN.
module tb_adc_spi_sampler;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, continuous = 1'b0, sdo = 1'b0;
   logic sck, cs_n, sample_valid, busy, avg_valid;
   logic [11:0] sample, avg;
   logic start2 = 1'b0, cont2 = 1'b0, sdo2 = 1'b0;
   logic sck2, cs2_n, sv2, busy2, av2;
   logic [7:0] sample2, avg2;
   int n_cmp = 0, n_bad = 0, cyc = 0;
   logic seen_avg = 1'b0;

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (avg_valid === 1'b1 || avg !== 12'h000) seen_avg <= 1'b1;

   adc_spi_sampler dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .sdo(sdo),
      .sck(sck), .cs_n(cs_n), .sample(sample), .sample_valid(sample_valid),
      .busy(busy), .avg(avg), .avg_valid(avg_valid));

   adc_spi_sampler #(.CLK_DIV(4), .DATA_W(8), .LEAD_BITS(2), .FRAME_LEN(12), .QUIET_CYC(1)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .continuous(cont2), .sdo(sdo2),
      .sck(sck2), .cs_n(cs2_n), .sample(sample2), .sample_valid(sv2),
      .busy(busy2), .avg(avg2), .avg_valid(av2));

   // ADC models: load a frame on cs_n fall, advance one bit per sck fall.
   logic [11:0] q1[$];
   logic [15:0] fw1;
   int idx1;
   logic p_cs1 = 1'b1, p_sck1 = 1'b0;
   always @(cs_n or sck) begin
      if (cs_n === 1'b0 && p_cs1 === 1'b1) begin
         fw1 = 16'h0000;
         if (q1.size() > 0) fw1[11:0] = q1.pop_front();
         idx1 = 0;
         sdo = fw1[15];
      end else if (cs_n === 1'b0 && sck === 1'b0 && p_sck1 === 1'b1) begin
         idx1++;
         sdo = (idx1 < 16) ? fw1[15-idx1] : 1'b0;
      end
      p_cs1 = cs_n;
      p_sck1 = sck;
   end

   logic [7:0] q2[$];
   logic [11:0] fw2;
   int idx2;
   logic p_cs2 = 1'b1, p_sck2 = 1'b0;
   always @(cs2_n or sck2) begin
      if (cs2_n === 1'b0 && p_cs2 === 1'b1) begin
         fw2 = 12'h000;
         if (q2.size() > 0) fw2[9:2] = q2.pop_front();
         idx2 = 0;
         sdo2 = fw2[11];
      end else if (cs2_n === 1'b0 && sck2 === 1'b0 && p_sck2 === 1'b1) begin
         idx2++;
         sdo2 = (idx2 < 12) ? fw2[11-idx2] : 1'b0;
      end
      p_cs2 = cs2_n;
      p_sck2 = sck2;
   end

   task automatic pulse_start(output int e);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      e = cyc;
   endtask

   task automatic wait_valid(input int budget, output bit ok, output int t, output logic [11:0] v);
      ok = 1'b0; t = 0; v = '0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (sample_valid === 1'b1) begin ok = 1'b1; t = cyc; v = sample; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
      n_cmp++; if (sck !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b want 0", sck); end
      n_cmp++; if ({sample, sample_valid, busy} !== 14'h0) begin n_bad++; $display("FAIL reset_outs: got %h/%b/%b want 0", sample, sample_valid, busy); end
      n_cmp++; if ({avg, avg_valid} !== 13'h0) begin n_bad++; $display("FAIL reset_avg: got %h/%b want 0", avg, avg_valid); end
      n_cmp++; if ({cs2_n, sck2, sample2, sv2, busy2} !== 12'h800) begin n_bad++; $display("FAIL reset_dut2: got %b%b %h %b%b want 1 0 00 00", cs2_n, sck2, sample2, sv2, busy2); end
      @(negedge clk) rst = 1'b1;
   endtask

   task automatic test_reset_midframe;
      int e, rises;
      logic prev;
      bit vseen;
      q1.push_back(12'h7FF);
      pulse_start(e);
      rises = 0; prev = 1'b0;
      for (int i = 0; i < 1000 && rises < 8; i++) begin
         @(negedge clk);
         if (sck === 1'b1 && prev === 1'b0) rises++;
         prev = sck;
      end
      n_cmp++; if (rises !== 8) begin n_bad++; $display("FAIL midframe_reach_bit7: got %0d rises want 8", rises); end
      rst = 1'b0;
      #1;
      n_cmp++; if ({cs_n, sck} !== 2'b10) begin n_bad++; $display("FAIL midframe_abort: got cs_n=%b sck=%b want 1 0", cs_n, sck); end
      n_cmp++; if ({busy, sample} !== 13'h0) begin n_bad++; $display("FAIL midframe_state: got busy=%b sample=%h want 0 000", busy, sample); end
      vseen = 1'b0;
      repeat (4) begin @(negedge clk); if (sample_valid !== 1'b0) vseen = 1'b1; end
      rst = 1'b1;
      repeat (1000) begin @(negedge clk); if (sample_valid !== 1'b0) vseen = 1'b1; end
      n_cmp++; if (vseen !== 1'b0) begin n_bad++; $display("FAIL midframe_no_valid: got valid seen=%b want 0", vseen); end
      n_cmp++; if (sample !== 12'h000) begin n_bad++; $display("FAIL midframe_sample: got %h want 000", sample); end
   endtask

   task automatic test_single;
      int e, lows, rises, highs, vcnt, vat;
      logic [11:0] vval;
      logic prev;
      q1.push_back(12'hA5C);
      pulse_start(e);
      lows = 0; rises = 0; highs = 0; vcnt = 0; vat = -1; vval = '0; prev = 1'b0;
      repeat (1000) begin
         if (cs_n === 1'b0) lows++;
         if (sck === 1'b1) highs++;
         if (sck === 1'b1 && prev === 1'b0) rises++;
         prev = sck;
         if (sample_valid === 1'b1) begin vcnt++; vat = cyc - e; vval = sample; end
         @(negedge clk);
      end
      n_cmp++; if (lows !== 825) begin n_bad++; $display("FAIL single_cs_low: got %0d want 825", lows); end
      n_cmp++; if (rises !== 16) begin n_bad++; $display("FAIL single_sck_pulses: got %0d want 16", rises); end
      n_cmp++; if (highs !== 400) begin n_bad++; $display("FAIL single_sck_high: got %0d want 400", highs); end
      n_cmp++; if (vcnt !== 1) begin n_bad++; $display("FAIL single_valid_count: got %0d want 1", vcnt); end
      n_cmp++; if (vat !== 825) begin n_bad++; $display("FAIL single_latency: got %0d want 825", vat); end
      n_cmp++; if (vval !== 12'hA5C) begin n_bad++; $display("FAIL single_value: got %h want a5c", vval); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_continuous;
      bit ok1, ok2, ok3;
      int t1, t2, t3, hi, extra;
      logic [11:0] v1, v2, v3;
      q1.push_back(12'h001); q1.push_back(12'hFFF); q1.push_back(12'h800);
      @(negedge clk) continuous = 1'b1;
      wait_valid(1200, ok1, t1, v1);
      hi = 0;
      while (cs_n === 1'b1 && hi < 500) begin hi++; @(negedge clk); end
      wait_valid(1200, ok2, t2, v2);
      for (int i = 0; i < 300 && cs_n !== 1'b0; i++) @(negedge clk);
      continuous = 1'b0;
      wait_valid(1200, ok3, t3, v3);
      extra = 0;
      repeat (1200) begin @(negedge clk); if (sample_valid === 1'b1) extra++; end
      n_cmp++; if ({ok1, ok2, ok3} !== 3'b111) begin n_bad++; $display("FAIL cont_timeouts: got %b%b%b want 111", ok1, ok2, ok3); end
      n_cmp++; if ({v1, v2, v3} !== 36'h001FFF800) begin n_bad++; $display("FAIL cont_values: got %h %h %h want 001 fff 800", v1, v2, v3); end
      n_cmp++; if (t2 - t1 !== 926) begin n_bad++; $display("FAIL cont_spacing12: got %0d want 926", t2 - t1); end
      n_cmp++; if (t3 - t2 !== 926) begin n_bad++; $display("FAIL cont_spacing23: got %0d want 926", t3 - t2); end
      n_cmp++; if (hi !== 101) begin n_bad++; $display("FAIL cont_cs_quiet: got %0d want 101", hi); end
      n_cmp++; if ({extra[7:0], busy} !== 9'h0) begin n_bad++; $display("FAIL cont_stop: got extra=%0d busy=%b want 0 0", extra, busy); end
   endtask

   task automatic test_pending;
      int e, vcnt, ta, tb;
      logic [11:0] vb;
      q1.push_back(12'h123); q1.push_back(12'h456);
      pulse_start(e);
      repeat (300) @(negedge clk);
      start = 1'b1; @(negedge clk) start = 1'b0;
      repeat (50) @(negedge clk);
      start = 1'b1; @(negedge clk) start = 1'b0;
      vcnt = 0; ta = 0; tb = 0; vb = '0;
      repeat (2600) begin
         @(negedge clk);
         if (sample_valid === 1'b1) begin
            vcnt++;
            if (vcnt == 1) ta = cyc - e; else begin tb = cyc - e; vb = sample; end
         end
      end
      n_cmp++; if (vcnt !== 2) begin n_bad++; $display("FAIL pending_count: got %0d want 2", vcnt); end
      n_cmp++; if (ta !== 825 || tb !== 1751) begin n_bad++; $display("FAIL pending_timing: got %0d,%0d want 825,1751", ta, tb); end
      n_cmp++; if (vb !== 12'h456) begin n_bad++; $display("FAIL pending_value: got %h want 456", vb); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pending_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_sweep;
      int e, lows, vat;
      logic [7:0] vval;
      q2.push_back(8'h3C);
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      e = cyc; lows = 0; vat = -1; vval = '0;
      repeat (100) begin
         if (cs2_n === 1'b0) lows++;
         if (sv2 === 1'b1) begin vat = cyc - e; vval = sample2; end
         @(negedge clk);
      end
      n_cmp++; if (vval !== 8'h3C) begin n_bad++; $display("FAIL sweep_value: got %h want 3c", vval); end
      n_cmp++; if (vat !== 50) begin n_bad++; $display("FAIL sweep_latency: got %0d want 50", vat); end
      n_cmp++; if (lows !== 50) begin n_bad++; $display("FAIL sweep_cs_low: got %0d want 50", lows); end
      n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL sweep_idle: got %b want 0", busy2); end
   endtask

   task automatic test_avg;
      bit ok;
      int t, nok;
      logic [11:0] v;
      q1.push_back(12'd100); q1.push_back(12'd101); q1.push_back(12'd102); q1.push_back(12'd104);
      @(negedge clk) continuous = 1'b1;
      nok = 0;
      for (int i = 0; i < 4; i++) begin
         wait_valid(1200, ok, t, v);
         if (ok) nok++;
      end
      continuous = 1'b0;
      n_cmp++; if (nok !== 4) begin n_bad++; $display("FAIL avg_samples: got %0d want 4", nok); end
      n_cmp++; if (avg_valid !== 1'b0) begin n_bad++; $display("FAIL avg_early: got %b want 0", avg_valid); end
      @(negedge clk);
`ifdef ADC_AVG_EN
      n_cmp++; if (avg_valid !== 1'b1) begin n_bad++; $display("FAIL avg_valid_pulse: got %b want 1", avg_valid); end
      n_cmp++; if (avg !== 12'd101) begin n_bad++; $display("FAIL avg_value: got %0d want 101", avg); end
      @(negedge clk);
      n_cmp++; if (avg_valid !== 1'b0) begin n_bad++; $display("FAIL avg_valid_width: got %b want 0", avg_valid); end
`else
      n_cmp++; if ({avg, avg_valid} !== 13'h0) begin n_bad++; $display("FAIL avg_tied: got %h/%b want 0", avg, avg_valid); end
      n_cmp++; if (seen_avg !== 1'b0) begin n_bad++; $display("FAIL avg_never: got %b want 0", seen_avg); end
`endif
      repeat (200) @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_reset_midframe;
      test_single;
      test_continuous;
      test_pending;
      test_sweep;
      test_avg;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
